// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes and FSM states shared by the SPI flash responder.
package spi_flash_pkg;
    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchronizer with registered rise/fall strobes (3 clk pin-to-strobe).
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [2:0] s;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s    <= {3{RST_VAL}};
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s    <= {s[1:0], d};
            rise <= s[1] & ~s[2];
            fall <= ~s[1] & s[2];
        end
    end
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI NOR-flash READ target serving bytes from a memory port.
// Define SPI_FLASH_RESPONDER_FAST_READ_EN to accept FAST_READ (0x0B) with 8 dummy clocks.
import spi_flash_pkg::*;
module spi_flash_responder #(
    parameter int   ADDR_W    = 24,
    parameter logic IDLE_MISO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic              busy,
    output logic              err_cmd,
    output logic              err_underrun
);
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif
    localparam int CW = $clog2(ADDR_W) + 1;

    state_t            state, state_nx;
    logic [CW-1:0]     bit_cnt, bit_cnt_nx;
    logic [ADDR_W-2:0] shift, shift_nx;
    logic [ADDR_W-1:0] addr_nx, din;
    logic [7:0]        pre, pre_nx, sh, sh_nx, byte_in, op;
    logic [2:0]        bcnt, bcnt_nx;
    logic [1:0]        mosi_s;
    logic pre_vld, pre_vld_nx, req_nx, miso_nx, fast, fast_nx, cs_on, cs_on_nx;
    logic err_cmd_nx, err_un_nx, sck_rise, sck_fall, cs_rise, cs_fall;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sck (.clk(clk), .rst_n(rst_n), .d(spi_clk), .rise(sck_rise), .fall(sck_fall));
    spi_sync_edge #(.RST_VAL(1'b1)) u_cs (.clk(clk), .rst_n(rst_n), .d(spi_cs_n), .rise(cs_rise), .fall(cs_fall));

    assign din         = {shift, mosi_s[1]};
    assign op          = din[7:0];
    assign byte_in     = pre_vld ? pre : 8'hFF;
    assign spi_miso_oe = (state == DATA);
    assign busy        = cs_on && (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift        <= '0;
            mem_addr     <= '0;
            mem_req      <= 1'b0;
            pre          <= '0;
            pre_vld      <= 1'b0;
            sh           <= '1;
            bcnt         <= '0;
            spi_miso     <= IDLE_MISO;
            fast         <= 1'b0;
            cs_on        <= 1'b0;
            err_cmd      <= 1'b0;
            err_underrun <= 1'b0;
            mosi_s       <= '0;
        end else begin
            state        <= state_nx;
            bit_cnt      <= bit_cnt_nx;
            shift        <= shift_nx;
            mem_addr     <= addr_nx;
            mem_req      <= req_nx;
            pre          <= pre_nx;
            pre_vld      <= pre_vld_nx;
            sh           <= sh_nx;
            bcnt         <= bcnt_nx;
            spi_miso     <= miso_nx;
            fast         <= fast_nx;
            cs_on        <= cs_on_nx;
            err_cmd      <= err_cmd_nx;
            err_underrun <= err_un_nx;
            mosi_s       <= {mosi_s[0], spi_mosi};
        end
    end

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift;
        addr_nx    = mem_addr;
        req_nx     = mem_req;
        pre_nx     = pre;
        pre_vld_nx = pre_vld;
        sh_nx      = sh;
        bcnt_nx    = bcnt;
        miso_nx    = spi_miso;
        fast_nx    = fast;
        err_cmd_nx = 1'b0;
        err_un_nx  = 1'b0;
        cs_on_nx   = cs_fall ? 1'b1 : cs_rise ? 1'b0 : cs_on;
        // A late ack still lands in the prefetch, even after an underrun.
        if (mem_req && mem_ack) begin
            req_nx     = 1'b0;
            pre_nx     = mem_data;
            pre_vld_nx = 1'b1;
        end
        case (state)
            IDLE: if (cs_fall) begin
                state_nx   = CMD;
                bit_cnt_nx = '0;
            end
            CMD: if (sck_rise) begin
                shift_nx   = din[ADDR_W-2:0];
                bit_cnt_nx = bit_cnt + 1'b1;
                if (bit_cnt == CW'(7)) begin
                    bit_cnt_nx = '0;
                    fast_nx    = (op == OP_FAST_READ);
                    if (op == OP_READ || (FAST_EN && op == OP_FAST_READ)) state_nx = ADDR;
                    else begin
                        state_nx   = IGNORE;
                        err_cmd_nx = 1'b1;
                    end
                end
            end
            ADDR: if (sck_rise) begin
                shift_nx   = din[ADDR_W-2:0];
                bit_cnt_nx = bit_cnt + 1'b1;
                if (bit_cnt == CW'(ADDR_W - 1)) begin
                    bit_cnt_nx = '0;
                    addr_nx    = din;
                    req_nx     = 1'b1;
                    pre_vld_nx = 1'b0;
                    bcnt_nx    = '0;
                    state_nx   = fast ? DUMMY : DATA;
                end
            end
            DUMMY: if (sck_rise) begin
                bit_cnt_nx = bit_cnt + 1'b1;
                if (bit_cnt == CW'(7)) state_nx = DATA;
            end
            DATA: if (sck_fall) begin
                bcnt_nx = bcnt + 1'b1;
                if (bcnt == 3'd0) begin
                    miso_nx   = byte_in[7];
                    sh_nx     = {byte_in[6:0], 1'b1};
                    err_un_nx = !pre_vld;
                    if (pre_vld) begin
                        pre_vld_nx = 1'b0;
                        addr_nx    = mem_addr + 1'b1;
                        req_nx     = 1'b1;
                    end
                end else begin
                    miso_nx = sh[7];
                    sh_nx   = {sh[6:0], 1'b1};
                end
            end
            default: ;
        endcase
        if (cs_rise) begin
            state_nx   = IDLE;
            req_nx     = 1'b0;
            pre_vld_nx = 1'b0;
        end
        miso_nx = (state_nx == DATA) ? miso_nx : IDLE_MISO;
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed SPI READ transactions against a memory model returning addr[7:0]^0xA5.
module tb_spi_flash_responder;
    logic        clk = 1'b0, rst_n = 1'b0, spi_clk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe, mem_req, mem_ack, busy, err_cmd, err_underrun;
    logic [23:0] mem_addr;
    logic [7:0]  mem_data;
    int          n_checks = 0, n_fail = 0;
    int          wait_cnt = 0, base_lat = 0;
    logic        slow_en = 1'b0;
    logic [23:0] slow_addr = '0;
    int          n_err_cmd = 0, n_err_un = 0, n_oe = 0;
    logic        req_q = 1'b0;
    logic [23:0] addr_log[$];

    always #5 clk = ~clk;

    spi_flash_responder dut (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_data(mem_data), .busy(busy), .err_cmd(err_cmd), .err_underrun(err_underrun)
    );

    always @(posedge clk) wait_cnt <= mem_req ? wait_cnt + 1 : 0;
    assign mem_ack  = mem_req && (wait_cnt >= ((slow_en && mem_addr == slow_addr) ? 100 : base_lat));
    assign mem_data = mem_addr[7:0] ^ 8'hA5;

    always @(negedge clk) begin
        if (mem_req && !req_q) addr_log.push_back(mem_addr);
        req_q = mem_req;
        n_err_cmd += int'(err_cmd);
        n_err_un  += int'(err_underrun);
        n_oe      += int'(spi_miso_oe);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic b, output logic m);
        spi_mosi = b;
        repeat (4) @(negedge clk);
        spi_clk = 1'b1;
        repeat (4) @(negedge clk);
        m = spi_miso;
        spi_clk = 1'b0;
    endtask

    task automatic xbyte(input logic [7:0] tx, output logic [7:0] rx);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            xfer(tx[i], m);
            rx[i] = m;
        end
    endtask

    task automatic deselect();
        spi_clk  = 1'b0;
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_read(input logic [7:0] op, input logic [23:0] a);
        logic [7:0] d;
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        xbyte(op, d);
        xbyte(a[23:16], d);
        xbyte(a[15:8], d);
        xbyte(a[7:0], d);
    endtask

    task automatic read_check(input string tag, input logic [7:0] exp);
        logic [7:0] d;
        xbyte(8'h00, d);
        check(tag, {24'h0, d}, {24'h0, exp});
    endtask

    initial begin
        int a0, e0, u0, o0;
        logic [7:0] d;
        logic m;
        repeat (4) @(negedge clk);
        check("rst_miso", {31'h0, spi_miso}, 1);
        check("rst_oe", {31'h0, spi_miso_oe}, 0);
        check("rst_req", {31'h0, mem_req}, 0);
        check("rst_addr", {8'h0, mem_addr}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_err_cmd", {31'h0, err_cmd}, 0);
        check("rst_err_un", {31'h0, err_underrun}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        a0 = addr_log.size(); u0 = n_err_un; e0 = n_err_cmd;
        send_read(8'h03, 24'h040000);
        read_check("basic_b0", 8'hA5);
        read_check("basic_b1", 8'hA4);
        read_check("basic_b2", 8'hA7);
        read_check("basic_b3", 8'hA6);
        check("basic_busy", {31'h0, busy}, 1);
        check("basic_oe", {31'h0, spi_miso_oe}, 1);
        deselect();
        check("basic_idle_busy", {31'h0, busy}, 0);
        check("basic_idle_oe", {31'h0, spi_miso_oe}, 0);
        check("basic_req_cnt", addr_log.size() - a0, 5);
        for (int i = 0; i < 5; i++)
            if (addr_log.size() > a0 + i) check($sformatf("basic_addr%0d", i), {8'h0, addr_log[a0+i]}, 32'h040000 + i);
        check("basic_no_err", n_err_un - u0 + n_err_cmd - e0, 0);

        a0 = addr_log.size();
        send_read(8'h03, 24'hFFFFFE);
        read_check("wrap_b0", 8'h5B);
        read_check("wrap_b1", 8'h5A);
        read_check("wrap_b2", 8'hA5);
        deselect();
        check("wrap_req_cnt", addr_log.size() - a0, 4);
        if (addr_log.size() >= a0 + 3) begin
            check("wrap_addr0", {8'h0, addr_log[a0]}, 32'hFFFFFE);
            check("wrap_addr1", {8'h0, addr_log[a0+1]}, 32'hFFFFFF);
            check("wrap_addr2", {8'h0, addr_log[a0+2]}, 32'h000000);
        end

        a0 = addr_log.size(); e0 = n_err_cmd; o0 = n_oe;
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        xbyte(8'h9F, d);
        xbyte(8'h00, d);
        check("badop_miso0", {24'h0, d}, 32'hFF);
        xbyte(8'h00, d);
        check("badop_miso1", {24'h0, d}, 32'hFF);
        check("badop_busy", {31'h0, busy}, 1);
        deselect();
        check("badop_err_cmd", n_err_cmd - e0, 1);
        check("badop_oe", n_oe - o0, 0);
        check("badop_no_req", addr_log.size() - a0, 0);

        a0 = addr_log.size();
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        xbyte(8'h03, d);
        for (int i = 0; i < 10; i++) xfer(1'b0, m);
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_addr_busy", {31'h0, busy}, 0);
        check("abort_addr_req", {31'h0, mem_req}, 0);
        check("abort_addr_no_req", addr_log.size() - a0, 0);
        repeat (4) @(negedge clk);
        send_read(8'h03, 24'h000055);
        read_check("abort_addr_next", 8'hF0);
        deselect();

        slow_en = 1'b1; slow_addr = 24'h000021;
        send_read(8'h03, 24'h000020);
        for (int i = 0; i < 3; i++) xfer(1'b0, m);
        check("abort_data_pending", {31'h0, mem_req}, 1);
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_data_busy", {31'h0, busy}, 0);
        check("abort_data_req", {31'h0, mem_req}, 0);
        repeat (4) @(negedge clk);
        slow_en = 1'b0;
        send_read(8'h03, 24'h000021);
        read_check("abort_data_next0", 8'h84);
        read_check("abort_data_next1", 8'h87);
        deselect();

        u0 = n_err_un;
        slow_en = 1'b1; slow_addr = 24'h000101;
        send_read(8'h03, 24'h000100);
        read_check("under_b0", 8'hA5);
        read_check("under_b1", 8'hFF);
        read_check("under_b2", 8'hA4);
        read_check("under_b3", 8'hA7);
        deselect();
        slow_en = 1'b0;
        check("under_pulses", n_err_un - u0, 1);

        a0 = addr_log.size(); e0 = n_err_cmd; u0 = n_err_un; o0 = n_oe;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
        base_lat = 6;
        send_read(8'h0B, 24'h000010);
        xbyte(8'h00, d);
        read_check("fast_b0", 8'hB5);
        read_check("fast_b1", 8'hB4);
        read_check("fast_b2", 8'hB7);
        read_check("fast_b3", 8'hB6);
        deselect();
        base_lat = 0;
        check("fast_no_under", n_err_un - u0, 0);
        check("fast_no_err_cmd", n_err_cmd - e0, 0);
        if (addr_log.size() > a0) check("fast_addr0", {8'h0, addr_log[a0]}, 32'h000010);
        else check("fast_addr0_missing", addr_log.size() - a0, 1);
`else
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        xbyte(8'h0B, d);
        xbyte(8'h00, d);
        check("fast_off_miso", {24'h0, d}, 32'hFF);
        deselect();
        check("fast_off_err_cmd", n_err_cmd - e0, 1);
        check("fast_off_no_req", addr_log.size() - a0, 0);
        check("fast_off_oe", n_oe - o0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
